// File: rtl/game_fsm.sv
// game_fsm: round controller for the flappy-bird datapath.
// Detects floor and pipe collisions, keeps the score and issues the
// one-cycle game_rst pulse that re-arms the bird-motion block.
module game_fsm #(
    parameter int SCREEN_HEIGHT = 768,
    parameter int BIRD_X        = 200,
    parameter int BIRD_SIZE     = 100,
    parameter int PIPE_W        = 80,
    parameter int GAP_H         = 250,
    parameter int DEAD_HOLD     = 60,
    parameter int SCORE_MAX     = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic        frame_tick,
    input  logic [10:0] BIRD_Y,
    input  logic [10:0] PIPE_X,
    input  logic [10:0] GAP_Y,
    output logic        game_rst,
    output logic        game_active,
    output logic        game_over,
    output logic [9:0]  score
);

    localparam int HW = (DEAD_HOLD < 1) ? 1 : $clog2(DEAD_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t        state;
    logic          mouse_left_d;
    logic          passed;
    logic [HW-1:0] hold_cnt;

    // Edge geometry, widened to 12 bits so no sum can wrap.
    logic [11:0] bird_top, bird_bot, pipe_left, pipe_right, gap_top, gap_bot;
    logic        click, floor_hit, x_ovl, pipe_hit, hit, pipe_behind;

    // Collision and scoring conditions from the current inputs.
    always_comb begin
        bird_top    = {1'b0, BIRD_Y};
        bird_bot    = {1'b0, BIRD_Y} + 12'(BIRD_SIZE);
        pipe_left   = {1'b0, PIPE_X};
        pipe_right  = {1'b0, PIPE_X} + 12'(PIPE_W);
        gap_top     = {1'b0, GAP_Y};
        gap_bot     = {1'b0, GAP_Y} + 12'(GAP_H);
        click       = mouse_left & ~mouse_left_d;
        floor_hit   = bird_bot >= 12'(SCREEN_HEIGHT);
        x_ovl       = (pipe_left < 12'(BIRD_X + BIRD_SIZE)) && (pipe_right > 12'(BIRD_X));
        pipe_hit    = x_ovl && ((bird_top < gap_top) || (bird_bot > gap_bot));
        hit         = floor_hit | pipe_hit;
        pipe_behind = pipe_right < 12'(BIRD_X);
    end

    // Round state machine with registered outputs; rst beats click and hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mouse_left_d <= 1'b0;
            passed       <= 1'b0;
            hold_cnt     <= '0;
            game_rst     <= 1'b0;
            game_active  <= 1'b0;
            game_over    <= 1'b0;
            score        <= '0;
        end else begin
            mouse_left_d <= mouse_left;
            game_rst     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (click) begin
                        state       <= S_PLAY;
                        game_rst    <= 1'b1;
                        game_active <= 1'b1;
                        game_over   <= 1'b0;
                        score       <= '0;
                        passed      <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        // A crash outranks a simultaneous score event.
                        state       <= S_DEAD;
                        game_active <= 1'b0;
                        game_over   <= 1'b1;
                        passed      <= 1'b0;
                        hold_cnt    <= '0;
                    end else if (pipe_behind) begin
                        if (!passed) begin
                            passed <= 1'b1;
                            if (score != 10'(SCORE_MAX))
                                score <= score + 10'd1;
                        end
                    end else begin
                        // Pipe wrapped back to the right: arm the next score.
                        passed <= 1'b0;
                    end
                end
                S_DEAD: begin
                    if (frame_tick && (hold_cnt != HW'(DEAD_HOLD)))
                        hold_cnt <= hold_cnt + 1'b1;
                    if (click && (hold_cnt == HW'(DEAD_HOLD))) begin
                        state       <= S_PLAY;
                        game_rst    <= 1'b1;
                        game_active <= 1'b1;
                        game_over   <= 1'b0;
                        score       <= '0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    game_active <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the round rules.
module tb_game_fsm;

    logic        clk = 1'b0;
    logic        rst, mouse_left, frame_tick;
    logic [10:0] BIRD_Y, PIPE_X, GAP_Y;
    logic        game_rst, game_active, game_over;
    logic [9:0]  score;

    game_fsm dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left), .frame_tick(frame_tick),
        .BIRD_Y(BIRD_Y), .PIPE_X(PIPE_X), .GAP_Y(GAP_Y),
        .game_rst(game_rst), .game_active(game_active), .game_over(game_over),
        .score(score)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are read at the next one.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; mouse_left = 1'b0; frame_tick = 1'b0;
        BIRD_Y = 11'd300; GAP_Y = 11'd250; PIPE_X = 11'd1000;
        cyc();
        rst = 1'b0;
    endtask

    task automatic start_round();
        BIRD_Y = 11'd300; GAP_Y = 11'd250; PIPE_X = 11'd1000;
        mouse_left = 1'b1; cyc();
        mouse_left = 1'b0; cyc();
    endtask

    typedef struct {
        int by; int px; int gy; int over; int sc;
    } vec_t;
    vec_t vt[11];

    // Behavioural reference: rules evaluated with plain integer arithmetic.
    int  m_mode;   // 0 idle, 1 playing, 2 crashed
    bit  m_ml_d, m_grst, m_passed;
    int  m_score, m_hold;

    task automatic model_step(input bit r, input bit ml, input bit ft,
                              input int by, input int px, input int gy);
        bit c, crash, behind;
        if (r) begin
            m_mode = 0; m_ml_d = 0; m_grst = 0; m_passed = 0; m_score = 0; m_hold = 0;
            return;
        end
        c      = ml && !m_ml_d;
        m_ml_d = ml;
        m_grst = 0;
        crash  = (by + 100 >= 768) ||
                 ((px < 300) && (px + 80 > 200) && ((by < gy) || (by + 100 > gy + 250)));
        behind = (px + 80 < 200);
        if (m_mode == 0) begin
            if (c) begin m_mode = 1; m_grst = 1; m_score = 0; m_passed = 0; end
        end else if (m_mode == 1) begin
            if (crash) begin m_mode = 2; m_passed = 0; m_hold = 0; end
            else if (behind) begin
                if (!m_passed) begin
                    m_passed = 1;
                    m_score  = (m_score >= 999) ? 999 : m_score + 1;
                end
            end else m_passed = 0;
        end else begin
            if (c && m_hold == 60) begin m_mode = 1; m_grst = 1; m_score = 0; end
            else if (ft && m_hold < 60) m_hold++;
        end
    endtask

    initial begin
        int pulses;
        int px;

        vt[0]  = '{668, 1000, 250, 1, 0};  // floor exactly reached
        vt[1]  = '{667, 1000, 250, 0, 0};  // one pixel above floor
        vt[2]  = '{300,  119, 250, 0, 1};  // pipe just behind the bird
        vt[3]  = '{300,  120, 250, 0, 0};  // pipe right edge touches bird_x
        vt[4]  = '{300,  299, 350, 1, 0};  // first overlap, bird above gap
        vt[5]  = '{300,  300, 350, 0, 0};  // pipe starts at bird right edge
        vt[6]  = '{400,  250, 250, 0, 0};  // bird bottom on gap bottom
        vt[7]  = '{401,  250, 250, 1, 0};  // bird bottom below gap
        vt[8]  = '{249,  250, 250, 1, 0};  // bird top above gap
        vt[9]  = '{  0,    0, 250, 0, 1};  // far behind, scores
        vt[10] = '{668,    0, 250, 1, 0};  // crash beats score

        // Reset state.
        do_reset();
        chk("reset_game_rst", game_rst, 0);
        chk("reset_active", game_active, 0);
        chk("reset_over", game_over, 0);
        chk("reset_score", score, 0);

        // Held button gives one pulse, in the first cycle.
        mouse_left = 1'b1;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) mouse_left = 1'b0;
            cyc();
            if (k == 0) chk("click_pulse_first", game_rst, 1);
            pulses += int'(game_rst);
        end
        chk("click_pulse_count", pulses, 1);
        chk("click_active", game_active, 1);
        chk("click_score", score, 0);

        // Single-cycle geometry table.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            start_round();
            BIRD_Y = 11'(vt[i].by); PIPE_X = 11'(vt[i].px); GAP_Y = 11'(vt[i].gy);
            cyc();
            chk($sformatf("vec%0d_over", i), game_over, vt[i].over);
            chk($sformatf("vec%0d_active", i), game_active, 1 - vt[i].over);
            chk($sformatf("vec%0d_score", i), score, vt[i].sc);
        end

        // Bird falling onto the floor.
        do_reset(); start_round();
        for (int y = 660; y <= 668; y++) begin
            BIRD_Y = 11'(y); cyc();
            chk($sformatf("floor_y%0d", y), game_over, (y == 668) ? 1 : 0);
        end

        // Pipe sweep through the gap: single score at 119, held below.
        do_reset(); start_round();
        for (int p = 400; p >= 0; p--) begin
            PIPE_X = 11'(p); cyc();
            if (p == 400 || p == 120 || p == 119 || p == 0) begin
                chk($sformatf("sweep_score_px%0d", p), score, (p <= 119) ? 1 : 0);
                chk($sformatf("sweep_over_px%0d", p), game_over, 0);
            end
        end
        PIPE_X = 11'd119; cyc();
        chk("sweep_no_rescore", score, 1);
        PIPE_X = 11'd120; cyc();
        PIPE_X = 11'd119; cyc();
        chk("sweep_rescore", score, 2);

        // Same sweep with the gap lowered: crash at 299.
        do_reset(); start_round();
        GAP_Y = 11'd350;
        for (int p = 400; p >= 299; p--) begin
            PIPE_X = 11'(p); cyc();
            if (p >= 300 && game_over) chk($sformatf("gap_early_px%0d", p), game_over, 0);
        end
        chk("gap_crash", game_over, 1);
        chk("gap_score", score, 0);

        // Dead hold: 59 ticks ignore the click, 60 accept it; score held.
        do_reset(); start_round();
        PIPE_X = 11'd100; cyc();
        PIPE_X = 11'd1000; cyc();
        BIRD_Y = 11'd700; cyc();
        chk("dead_over", game_over, 1);
        BIRD_Y = 11'd300;
        frame_tick = 1'b1; repeat (59) cyc(); frame_tick = 1'b0;
        mouse_left = 1'b1; cyc();
        chk("dead59_no_rst", game_rst, 0);
        chk("dead59_over", game_over, 1);
        chk("dead_score_held", score, 1);
        mouse_left = 1'b0; cyc();
        frame_tick = 1'b1; repeat (4) cyc(); frame_tick = 1'b0;
        mouse_left = 1'b1; cyc();
        chk("dead60_rst", game_rst, 1);
        chk("dead60_active", game_active, 1);
        chk("dead60_score", score, 0);
        mouse_left = 1'b0; cyc();
        chk("dead60_rst_single", game_rst, 0);

        // Reset mid-round with a score of 5 and a simultaneous click.
        do_reset(); start_round();
        repeat (5) begin
            PIPE_X = 11'd100; cyc();
            PIPE_X = 11'd1000; cyc();
        end
        chk("mid_score5", score, 5);
        rst = 1'b1; mouse_left = 1'b1; cyc();
        chk("mid_rst_game_rst", game_rst, 0);
        chk("mid_rst_active", game_active, 0);
        chk("mid_rst_over", game_over, 0);
        chk("mid_rst_score", score, 0);
        rst = 1'b0; mouse_left = 1'b0; cyc();
        chk("mid_after_active", game_active, 0);

        // Randomized run against the model.
        px = 1000;
        rst = 1'b1; mouse_left = 1'b0; frame_tick = 1'b0;
        model_step(1, 0, 0, 300, 1000, 250);
        cyc();
        for (int n = 0; n < 4000; n++) begin
            int by, gy;
            rst        = ($urandom_range(0, 299) == 0);
            mouse_left = ($urandom_range(0, 3) == 0);
            frame_tick = ($urandom_range(0, 1) == 0);
            px = px - int'($urandom_range(0, 12));
            if (px < 0) px = 1000;
            gy = 200 + int'($urandom_range(0, 60));
            by = gy + int'($urandom_range(0, 160)) - 5;
            if ($urandom_range(0, 60) == 0) by = int'($urandom_range(600, 767));
            BIRD_Y = 11'(by); PIPE_X = 11'(px); GAP_Y = 11'(gy);
            model_step(rst, mouse_left, frame_tick, by, px, gy);
            cyc();
            chk("rand_game_rst", game_rst, m_grst);
            chk("rand_active", game_active, (m_mode == 1) ? 1 : 0);
            chk("rand_over", game_over, (m_mode == 2) ? 1 : 0);
            chk("rand_score", score, m_score);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
